sirv_multi_deglitch: RTL and testbench

SIRV_MULTI_DEGLITCH -- requirements
Module: sirv_multi_deglitch

---
 rtl/sirv_deglitch_pkg.sv | 23 ++
 rtl/sirv_multi_deglitch_if.sv | 42 ++++
 rtl/sirv_deglitch_chan.sv | 102 ++++++++++
 rtl/sirv_multi_deglitch.sv | 67 ++++++
 tb/tb_sirv_multi_deglitch.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sirv_deglitch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sirv_deglitch_pkg
// Description : Shared defaults and legal parameter ranges for the
//               multi-channel deglitch filter.
// Revision    : 1.0 - initial release
// ============================================================================
package sirv_deglitch_pkg;

    localparam int   DEF_WIDTH       = 4;
    localparam int   DEF_SYNC_STAGES = 3;
    localparam int   SYNC_STAGES_MIN = 2;
    localparam int   SYNC_STAGES_MAX = 4;
    localparam int   DEF_CNT_W       = 8;
    localparam logic DEF_RESET_VAL   = 1'b0;

    // True when a synchroniser depth is within the supported range.
    function automatic bit sync_stages_legal(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage : sirv_deglitch_pkg
`default_nettype wire

// File: rtl/sirv_multi_deglitch_if.sv
`default_nettype none
// ============================================================================
// Module      : sirv_multi_deglitch_if
// Description : Bundle of the filter's data/control/status signals.
//               master : the block driving raw inputs and control
//               slave  : the deglitch filter itself
// Signals     : io_d, io_en, io_thresh, io_rise_en, io_fall_en, io_pend_clr
//               (master -> slave); io_q, io_rise, io_fall, io_pend, io_irq
//               (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface sirv_multi_deglitch_if
    import sirv_deglitch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [WIDTH-1:0] io_d;
    logic             io_en;
    logic [CNT_W-1:0] io_thresh;
    logic [WIDTH-1:0] io_rise_en;
    logic [WIDTH-1:0] io_fall_en;
    logic [WIDTH-1:0] io_pend_clr;
    logic [WIDTH-1:0] io_q;
    logic [WIDTH-1:0] io_rise;
    logic [WIDTH-1:0] io_fall;
    logic [WIDTH-1:0] io_pend;
    logic             io_irq;

    modport master (
        output io_d, io_en, io_thresh, io_rise_en, io_fall_en, io_pend_clr,
        input  io_q, io_rise, io_fall, io_pend, io_irq
    );

    modport slave (
        input  io_d, io_en, io_thresh, io_rise_en, io_fall_en, io_pend_clr,
        output io_q, io_rise, io_fall, io_pend, io_irq
    );

endinterface : sirv_multi_deglitch_if
`default_nettype wire

// File: rtl/sirv_deglitch_chan.sv
`default_nettype none
// ============================================================================
// Module      : sirv_deglitch_chan
// Description : One deglitch channel: synchroniser chain, stability counter,
//               filtered level, registered edge pulses and sticky pending bit.
// Ports       : clock, reset     - clock, async active-high reset
//               d                - raw asynchronous input
//               en               - filter enable (freezes level when 0)
//               thresh           - stable cycles required (0 acts as 1)
//               rise_en, fall_en - edge event enables
//               pend_clr         - write-one-to-clear for pend
//               q                - filtered level
//               rise, fall       - one-cycle edge pulses
//               pend             - sticky event flag
// Revision    : 1.0 - initial release
// ============================================================================
module sirv_deglitch_chan
    import sirv_deglitch_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   CNT_W       = DEF_CNT_W,
    parameter logic RESET_VAL   = DEF_RESET_VAL
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             d,
    input  wire logic             en,
    input  wire logic [CNT_W-1:0] thresh,
    input  wire logic             rise_en,
    input  wire logic             fall_en,
    input  wire logic             pend_clr,
    output logic                  q,
    output logic                  rise,
    output logic                  fall,
    output logic                  pend
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   r_q_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_pend;

    logic                   w_sync;
    logic [CNT_W-1:0]       w_thr_eff;
    logic [CNT_W:0]         w_cnt_inc;
    logic                   w_hit;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    // A threshold of zero is treated as one so the level always needs at
    // least one confirming cycle after synchronisation.
    assign w_thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;
    // One extra bit keeps the increment from wrapping; >= (not ==) lets a
    // threshold lowered below the running count take effect immediately.
    assign w_cnt_inc = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(1);
    assign w_hit     = (w_cnt_inc >= {1'b0, w_thr_eff});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync   <= {SYNC_STAGES{RESET_VAL}};
            r_cnt    <= '0;
            r_q      <= RESET_VAL;
            r_q_prev <= RESET_VAL;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            // Synchroniser runs regardless of the enable.
            r_sync   <= {r_sync[SYNC_STAGES-2:0], d};
            r_q_prev <= r_q;

            if (w_sync == r_q) begin
                r_cnt <= '0;
            end else if (en) begin
                if (w_hit) begin
                    r_q   <= w_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                end
            end else begin
                r_cnt <= '0;
            end

            // Pulses follow the cycle in which the filtered level moved.
            r_rise <= en & rise_en &  r_q & ~r_q_prev;
            r_fall <= en & fall_en & ~r_q &  r_q_prev;

            // Set wins over a coincident clear.
            r_pend <= r_rise | r_fall | (r_pend & ~pend_clr);
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign pend = r_pend;

endmodule : sirv_deglitch_chan
`default_nettype wire

// File: rtl/sirv_multi_deglitch.sv
`default_nettype none
// ============================================================================
// Module      : sirv_multi_deglitch
// Description : WIDTH independent deglitch channels sharing threshold and
//               enable, with a combined interrupt from the pending bits.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-high reset
//               bus    - slave side of sirv_multi_deglitch_if (io_d, io_en,
//                        io_thresh, io_rise_en, io_fall_en, io_pend_clr in;
//                        io_q, io_rise, io_fall, io_pend, io_irq out)
// Revision    : 1.0 - initial release
// ============================================================================
module sirv_multi_deglitch
    import sirv_deglitch_pkg::*;
#(
    parameter int   WIDTH       = DEF_WIDTH,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   CNT_W       = DEF_CNT_W,
    parameter logic RESET_VAL   = DEF_RESET_VAL
) (
    input  wire logic              clock,
    input  wire logic              reset,
    sirv_multi_deglitch_if.slave   bus
);

    generate
        if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
            $error("SYNC_STAGES out of supported range");
        end
    endgenerate

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_pend;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            sirv_deglitch_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W),
                .RESET_VAL   (RESET_VAL)
            ) u_chan (
                .clock    (clock),
                .reset    (reset),
                .d        (bus.io_d[i]),
                .en       (bus.io_en),
                .thresh   (bus.io_thresh),
                .rise_en  (bus.io_rise_en[i]),
                .fall_en  (bus.io_fall_en[i]),
                .pend_clr (bus.io_pend_clr[i]),
                .q        (w_q[i]),
                .rise     (w_rise[i]),
                .fall     (w_fall[i]),
                .pend     (w_pend[i])
            );
        end
    endgenerate

    assign bus.io_q    = w_q;
    assign bus.io_rise = w_rise;
    assign bus.io_fall = w_fall;
    assign bus.io_pend = w_pend;
    assign bus.io_irq  = |w_pend;

endmodule : sirv_multi_deglitch
`default_nettype wire

// File: tb/tb_sirv_multi_deglitch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sirv_multi_deglitch
// Description : Directed self-checking bench for sirv_multi_deglitch. One
//               instance uses defaults, a second uses RESET_VAL=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sirv_multi_deglitch;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    sirv_multi_deglitch_if #(.WIDTH(4), .CNT_W(8)) bus0 ();
    sirv_multi_deglitch_if #(.WIDTH(4), .CNT_W(8)) bus1 ();

    sirv_multi_deglitch u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    sirv_multi_deglitch #(.RESET_VAL(1'b1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus0.io_d = 4'h0; bus0.io_en = 1'b1; bus0.io_thresh = 8'd5;
        bus0.io_rise_en = 4'hF; bus0.io_fall_en = 4'hF; bus0.io_pend_clr = 4'h0;
        bus1.io_d = 4'hF; bus1.io_en = 1'b1; bus1.io_thresh = 8'd5;
        bus1.io_rise_en = 4'hF; bus1.io_fall_en = 4'hF; bus1.io_pend_clr = 4'h0;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++;
        if (bus0.io_q !== 4'h0 || bus0.io_rise !== 4'h0 || bus0.io_fall !== 4'h0 ||
            bus0.io_pend !== 4'h0 || bus0.io_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset0: q=%h rise=%h fall=%h pend=%h irq=%b, required q=0 rise=0 fall=0 pend=0 irq=0",
                     bus0.io_q, bus0.io_rise, bus0.io_fall, bus0.io_pend, bus0.io_irq);
        end
        checks++;
        if (bus1.io_q !== 4'hF || bus1.io_pend !== 4'h0) begin
            errors++;
            $display("FAIL reset1: q=%h pend=%h, required q=f pend=0", bus1.io_q, bus1.io_pend);
        end
    endtask

    // Step on channel 0 with thresh=5: level after 3+5 edges, pulse one later.
    task automatic test_latency();
        bus0.io_thresh = 8'd5;
        bus0.io_d[0]   = 1'b1;
        tick(7);
        checks++;
        if (bus0.io_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL lat_edge7: q0=%b, required 0", bus0.io_q[0]);
        end
        tick(1);
        checks++;
        if (bus0.io_q[0] !== 1'b1 || bus0.io_rise[0] !== 1'b0) begin
            errors++;
            $display("FAIL lat_edge8: q0=%b rise0=%b, required q0=1 rise0=0", bus0.io_q[0], bus0.io_rise[0]);
        end
        tick(1);
        checks++;
        if (bus0.io_rise[0] !== 1'b1 || bus0.io_pend[0] !== 1'b0) begin
            errors++;
            $display("FAIL lat_rise: rise0=%b pend0=%b, required rise0=1 pend0=0", bus0.io_rise[0], bus0.io_pend[0]);
        end
        tick(1);
        checks++;
        if (bus0.io_rise[0] !== 1'b0 || bus0.io_pend[0] !== 1'b1 || bus0.io_irq !== 1'b1) begin
            errors++;
            $display("FAIL lat_pend: rise0=%b pend0=%b irq=%b, required rise0=0 pend0=1 irq=1",
                     bus0.io_rise[0], bus0.io_pend[0], bus0.io_irq);
        end
    endtask

    // Three-cycle pulse on channel 1 is shorter than thresh=5.
    task automatic test_glitch();
        bus0.io_d[1] = 1'b1;
        tick(3);
        bus0.io_d[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            checks++;
            if (bus0.io_q[1] !== 1'b0 || bus0.io_rise[1] !== 1'b0 || bus0.io_pend[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch cyc%0d: q1=%b rise1=%b pend1=%b, required all 0",
                         k, bus0.io_q[1], bus0.io_rise[1], bus0.io_pend[1]);
            end
        end
    endtask

    // thresh=0 acts as 1: step reaches q after 3+1 edges.
    task automatic test_thresh_zero();
        bus0.io_thresh = 8'd0;
        bus0.io_d[2]   = 1'b1;
        tick(3);
        checks++;
        if (bus0.io_q[2] !== 1'b0) begin
            errors++;
            $display("FAIL thr0_edge3: q2=%b, required 0", bus0.io_q[2]);
        end
        tick(1);
        checks++;
        if (bus0.io_q[2] !== 1'b1) begin
            errors++;
            $display("FAIL thr0_edge4: q2=%b, required 1", bus0.io_q[2]);
        end
        tick(2);
        checks++;
        if (bus0.io_pend[2] !== 1'b1) begin
            errors++;
            $display("FAIL thr0_pend: pend2=%b, required 1", bus0.io_pend[2]);
        end
        bus0.io_pend_clr = 4'b0100;
        tick(1);
        bus0.io_pend_clr = 4'b0000;
        checks++;
        if (bus0.io_pend !== 4'b0001) begin
            errors++;
            $display("FAIL thr0_clr: pend=%b, required 0001", bus0.io_pend);
        end
    endtask

    // Clear coinciding with a new fall pulse is overridden; clear alone wins.
    task automatic test_pend_clear();
        bus0.io_thresh = 8'd1;
        bus0.io_d[0]   = 1'b0;
        tick(4);
        checks++;
        if (bus0.io_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL pc_q: q0=%b, required 0", bus0.io_q[0]);
        end
        tick(1);
        checks++;
        if (bus0.io_fall[0] !== 1'b1) begin
            errors++;
            $display("FAIL pc_fall: fall0=%b, required 1", bus0.io_fall[0]);
        end
        bus0.io_pend_clr = 4'b0001;
        tick(1);
        checks++;
        if (bus0.io_pend[0] !== 1'b1 || bus0.io_fall[0] !== 1'b0) begin
            errors++;
            $display("FAIL pc_setwins: pend0=%b fall0=%b, required pend0=1 fall0=0", bus0.io_pend[0], bus0.io_fall[0]);
        end
        tick(1);
        bus0.io_pend_clr = 4'b0000;
        checks++;
        if (bus0.io_pend[0] !== 1'b0 || bus0.io_irq !== 1'b0) begin
            errors++;
            $display("FAIL pc_clear: pend0=%b irq=%b, required pend0=0 irq=0", bus0.io_pend[0], bus0.io_irq);
        end
    endtask

    // Disabled filter freezes channel 3 while input toggles.
    task automatic test_enable();
        bus0.io_thresh = 8'd5;
        bus0.io_en     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus0.io_d[3] = ~bus0.io_d[3];
            tick(1);
            checks++;
            if (bus0.io_q[3] !== 1'b0 || bus0.io_rise[3] !== 1'b0 || bus0.io_fall[3] !== 1'b0) begin
                errors++;
                $display("FAIL en_off cyc%0d: q3=%b rise3=%b fall3=%b, required all 0",
                         k, bus0.io_q[3], bus0.io_rise[3], bus0.io_fall[3]);
            end
        end
        bus0.io_d[3] = 1'b1;
        tick(4);
        checks++;
        if (bus0.io_q[3] !== 1'b0) begin
            errors++;
            $display("FAIL en_settle: q3=%b, required 0", bus0.io_q[3]);
        end
        bus0.io_en = 1'b1;
        tick(4);
        checks++;
        if (bus0.io_q[3] !== 1'b0) begin
            errors++;
            $display("FAIL en_edge4: q3=%b, required 0", bus0.io_q[3]);
        end
        tick(1);
        checks++;
        if (bus0.io_q[3] !== 1'b1) begin
            errors++;
            $display("FAIL en_edge5: q3=%b, required 1", bus0.io_q[3]);
        end
    endtask

    // RESET_VAL=1 instance: reset mid-count acts without a clock edge.
    task automatic test_reset_mid_count();
        bus1.io_thresh = 8'd5;
        bus1.io_d      = 4'h0;
        tick(6);
        checks++;
        if (u_dut1.g_chan[0].u_chan.r_cnt !== 8'd3 || bus1.io_q !== 4'hF) begin
            errors++;
            $display("FAIL mid_cnt: cnt0=%0d q=%h, required cnt0=3 q=f",
                     u_dut1.g_chan[0].u_chan.r_cnt, bus1.io_q);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus1.io_q !== 4'hF || u_dut1.g_chan[0].u_chan.r_cnt !== 8'd0 ||
            bus1.io_pend !== 4'h0 || bus1.io_irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: q=%h cnt0=%0d pend=%h irq=%b, required q=f cnt0=0 pend=0 irq=0",
                     bus1.io_q, u_dut1.g_chan[0].u_chan.r_cnt, bus1.io_pend, bus1.io_irq);
        end
        bus1.io_d = 4'hF;
        tick(2);
        reset = 1'b0;
        tick(10);
        checks++;
        if (bus1.io_q !== 4'hF || bus1.io_fall !== 4'h0 || bus1.io_pend !== 4'h0) begin
            errors++;
            $display("FAIL mid_after: q=%h fall=%h pend=%h, required q=f fall=0 pend=0",
                     bus1.io_q, bus1.io_fall, bus1.io_pend);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_latency();
        test_glitch();
        test_thresh_zero();
        test_pend_clear();
        test_enable();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sirv_multi_deglitch
`default_nettype wire
